// File: rtl/mul_sequencer_pkg.sv
// mul_sequencer_pkg: shared state type, default width and counter sizing for the multiply sequencer
package mul_sequencer_pkg;
  localparam int WIDTH_DEF = 16;
  typedef enum logic [2:0] {
    IDLE = 3'b001,
    RUN  = 3'b010,
    DONE = 3'b100
  } state_t;
  function automatic int cnt_w(input int w);
    return $clog2(w);
  endfunction
endpackage

// File: rtl/mul_sequencer_if.sv
// mul_sequencer_if: start/operand request and busy/done/product/cnt_zero response bundle
//   master: drives start, a, b; observes busy, done, product, cnt_zero
//   slave:  the multiplier side of the same signals
interface mul_sequencer_if
  import mul_sequencer_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) ();
  logic               start;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] product;
  logic               cnt_zero;
  modport master (output start, a, b, input busy, done, product, cnt_zero);
  modport slave (input start, a, b, output busy, done, product, cnt_zero);
endinterface

// File: rtl/mul_iter_counter.sv
// mul_iter_counter: loadable down-counter with a registered zero flag that never wraps
//   clk, reset : clock and synchronous active-high reset (count 0, zero 1)
//   load       : load load_val (takes priority over en)
//   en         : decrement by one unless already at zero
//   load_val   : value loaded on load
//   zero       : registered (count == 0)
module mul_iter_counter #(
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic          en,
  input  logic [CW-1:0] load_val,
  output logic          zero
);
  logic [CW-1:0] cnt;
  // zero is computed from the next count so it tracks cnt without a combinational path
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt  <= '0;
      zero <= 1'b1;
    end else if (load) begin
      cnt  <= load_val;
      zero <= load_val == '0;
    end else if (en && !zero) begin
      cnt  <= cnt - 1'b1;
      zero <= cnt == CW'(1);
    end
  end
endmodule

// File: rtl/mul_sequencer.sv
// mul_sequencer: iterative shift-add multiplier, one add-shift step per clock
//   clk, reset : clock and synchronous active-high reset
//   bus.start  : request pulse, accepted only in IDLE; bus.a/bus.b sampled then
//   bus.busy   : high in RUN and DONE
//   bus.done   : one-cycle pulse, product valid while high
//   bus.product: {accumulator, multiplier} register, 2*WIDTH bits
//   bus.cnt_zero: registered iteration-counter-zero flag
// Build option: MUL_SIGNED_EN selects two's complement operands and product.
module mul_sequencer
  import mul_sequencer_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input logic clk,
  input logic reset,
  mul_sequencer_if.slave bus
);
  localparam int CW = cnt_w(WIDTH);
  state_t           state;
  logic [WIDTH-1:0] mcand, mplier, acc;
  logic [WIDTH:0]   sum;
  logic             busy, done, cnt_zero, load, step;
  assign load = (state == IDLE) && bus.start;
  assign step = state == RUN;
`ifdef MUL_SIGNED_EN
  logic [WIDTH:0] ext, acc_x;
  assign ext   = {mcand[WIDTH-1], mcand};
  assign acc_x = {acc[WIDTH-1], acc};
  // the last multiplier bit carries negative weight, so the final step subtracts
  assign sum = !mplier[0] ? acc_x : cnt_zero ? acc_x - ext : acc_x + ext;
`else
  assign sum = {1'b0, acc} + (mplier[0] ? {1'b0, mcand} : '0);
`endif
  mul_iter_counter #(.CW(CW)) u_cnt (
    .clk(clk),
    .reset(reset),
    .load(load),
    .en(step),
    .load_val(CW'(WIDTH - 1)),
    .zero(cnt_zero)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
    end else begin
      done <= 1'b0;
      if (load) begin
        mcand  <= bus.a;
        mplier <= bus.b;
        acc    <= '0;
        state  <= RUN;
        busy   <= 1'b1;
      end else if (step) begin
        // shift {carry/sign, acc, multiplier} right by one
        acc    <= sum[WIDTH:1];
        mplier <= {sum[0], mplier[WIDTH-1:1]};
        if (cnt_zero) begin
          state <= DONE;
          done  <= 1'b1;
        end
      end else if (state == DONE) begin
        state <= IDLE;
        busy  <= 1'b0;
      end
    end
  end
  assign bus.busy     = busy;
  assign bus.done     = done;
  assign bus.product  = {acc, mplier};
  assign bus.cnt_zero = cnt_zero;
endmodule

// File: tb/tb_mul_sequencer.sv
// tb_mul_sequencer: scoreboard bench for mul_sequencer at WIDTH=16
module tb_mul_sequencer;
  localparam int W = 16;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  mul_sequencer_if #(.WIDTH(W)) bus ();
  mul_sequencer #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus.slave));
  logic [2*W-1:0] sb[$];
  int vectors = 0;
  int miss = 0;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2*W-1:0] model(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [2*W-1:0] p;
`ifdef MUL_SIGNED_EN
    p = {{W{x[W-1]}}, x} * {{W{y[W-1]}}, y};
`else
    p = {{W{1'b0}}, x} * {{W{1'b0}}, y};
`endif
    return p;
  endfunction

  task automatic test_reset;
    reset = 1'b1;
    bus.start = 1'b1;
    bus.a = 16'h1234;
    bus.b = 16'h5678;
    tick;
    tick;
    vectors++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      miss++;
      $display("FAIL reset_ctrl busy=%b done=%b expected 0 0", bus.busy, bus.done);
    end
    vectors++;
    if (bus.product !== '0) begin
      miss++;
      $display("FAIL reset_product got %h expected 0", bus.product);
    end
    vectors++;
    if (bus.cnt_zero !== 1'b1) begin
      miss++;
      $display("FAIL reset_cnt_zero got %b expected 1", bus.cnt_zero);
    end
    reset = 1'b0;
    bus.start = 1'b0;
    tick;
    vectors++;
    if (bus.busy !== 1'b0) begin
      miss++;
      $display("FAIL reset_start_dropped busy=%b expected 0", bus.busy);
    end
  endtask

  task automatic op(input logic [W-1:0] x, input logic [W-1:0] y, input logic [2*W-1:0] e);
    logic [2*W-1:0] exp_p;
    vectors++;
    if (bus.cnt_zero !== 1'b1) begin
      miss++;
      $display("FAIL cz_idle got %b expected 1", bus.cnt_zero);
    end
    sb.push_back(e);
    bus.a = x;
    bus.b = y;
    bus.start = 1'b1;
    tick;
    bus.start = 1'b0;
    exp_p = e;
    for (int c = 1; c <= W + 2; c++) begin
      vectors++;
      if (bus.busy !== (c <= W + 1)) begin
        miss++;
        $display("FAIL op_busy cycle %0d got %b expected %b", c, bus.busy, c <= W + 1);
      end
      vectors++;
      if (bus.cnt_zero !== (c >= W)) begin
        miss++;
        $display("FAIL op_cnt_zero cycle %0d got %b expected %b", c, bus.cnt_zero, c >= W);
      end
      vectors++;
      if (bus.done !== (c == W + 1)) begin
        miss++;
        $display("FAIL op_done cycle %0d got %b expected %b", c, bus.done, c == W + 1);
      end
      if (bus.done === 1'b1 && sb.size() > 0) begin
        exp_p = sb.pop_front();
        vectors++;
        if (bus.product !== exp_p) begin
          miss++;
          $display("FAIL op_product %h*%h got %h expected %h", x, y, bus.product, exp_p);
        end
      end
      tick;
    end
    vectors++;
    if (bus.product !== exp_p) begin
      miss++;
      $display("FAIL op_hold %h*%h got %h expected %h", x, y, bus.product, exp_p);
    end
    if (sb.size() != 0) begin
      vectors++;
      miss++;
      $display("FAIL op_no_done %h*%h got no done expected %h", x, y, sb[0]);
      sb.delete();
    end
  endtask

  task automatic test_basic;
`ifdef MUL_SIGNED_EN
    op(16'h0003, 16'h0005, 32'h0000000F);
    op(16'hFFFF, 16'hFFFF, 32'h00000001);
    op(16'hFFFF, 16'h0002, 32'hFFFFFFFE);
    op(16'h8000, 16'h8000, 32'h40000000);
`else
    op(16'h0003, 16'h0005, 32'h0000000F);
    op(16'hFFFF, 16'hFFFF, 32'hFFFE0001);
    op(16'hFFFF, 16'h0002, 32'h0001FFFE);
    op(16'h8000, 16'h8000, 32'h40000000);
`endif
    op(16'h0000, 16'hABCD, 32'h00000000);
    op(16'h7FFF, 16'h8000, model(16'h7FFF, 16'h8000));
    for (int i = 0; i < 4; i++) begin
      logic [W-1:0] x, y;
      x = W'($urandom_range(0, 65535));
      y = W'($urandom_range(0, 65535));
      op(x, y, model(x, y));
    end
  endtask

  task automatic test_back_to_back;
    logic [W-1:0] a0, b0, a1, b1;
    logic [2*W-1:0] e;
    a0 = 16'h1234;
    b0 = 16'h00FF;
    a1 = 16'hABCD;
    b1 = 16'h7777;
    sb.push_back(model(a0, b0));
    bus.a = a0;
    bus.b = b0;
    bus.start = 1'b1;
    tick;
    for (int c = 1; c <= 2 * W + 4; c++) begin
      bus.start = (c == 5 || c == 17 || c == 18);
      bus.a = c == 18 ? a1 : 16'hFFFF;
      bus.b = c == 18 ? b1 : 16'hFFFF;
      if (c == 18) sb.push_back(model(a1, b1));
      vectors++;
      if (bus.done !== (c == 17 || c == 35)) begin
        miss++;
        $display("FAIL b2b_done cycle %0d got %b expected %b", c, bus.done, c == 17 || c == 35);
      end
      vectors++;
      if (bus.busy !== (c <= 17 || (c >= 19 && c <= 35))) begin
        miss++;
        $display("FAIL b2b_busy cycle %0d got %b expected %b", c, bus.busy, c <= 17 || (c >= 19 && c <= 35));
      end
      if (bus.done === 1'b1 && sb.size() > 0) begin
        e = sb.pop_front();
        vectors++;
        if (bus.product !== e) begin
          miss++;
          $display("FAIL b2b_product cycle %0d got %h expected %h", c, bus.product, e);
        end
      end
      tick;
    end
    bus.start = 1'b0;
    if (sb.size() != 0) begin
      vectors++;
      miss++;
      $display("FAIL b2b_no_done got none expected %h", sb[0]);
      sb.delete();
    end
  endtask

  task automatic test_reset_mid;
    bus.a = 16'h00FF;
    bus.b = 16'h0F0F;
    bus.start = 1'b1;
    tick;
    bus.start = 1'b0;
    for (int c = 1; c < 8; c++) tick;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    vectors++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      miss++;
      $display("FAIL mid_reset_ctrl busy=%b done=%b expected 0 0", bus.busy, bus.done);
    end
    vectors++;
    if (bus.product !== '0) begin
      miss++;
      $display("FAIL mid_reset_product got %h expected 0", bus.product);
    end
    vectors++;
    if (bus.cnt_zero !== 1'b1) begin
      miss++;
      $display("FAIL mid_reset_cnt_zero got %b expected 1", bus.cnt_zero);
    end
    for (int c = 0; c < 20; c++) begin
      tick;
      vectors++;
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
        miss++;
        $display("FAIL mid_reset_quiet cycle %0d done=%b busy=%b expected 0 0", c, bus.done, bus.busy);
      end
    end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.a = '0;
    bus.b = '0;
    test_reset;
    test_basic;
    test_back_to_back;
    test_reset_mid;
    op(16'h0003, 16'h0005, 32'h0000000F);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miss);
    $finish;
  end
endmodule
